// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with word-by-word line refill.
// Core and memory sides both use a held-request / one-cycle-valid handshake.
module inst_cache #(
    parameter int DATA_WIDTH     = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_req,
    input  logic [DATA_WIDTH-1:0] inst_addr,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst_data,
    input  logic                  flush,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = DATA_WIDTH - 2 - OFF_W - IDX_W;
    localparam logic [DATA_WIDTH-1:0] LINE_MASK = DATA_WIDTH'(WORDS_PER_LINE * 4 - 1);

    if (WORDS_PER_LINE < 2 || (1 << OFF_W) != WORDS_PER_LINE) begin : g_bad_wpl
        $error("inst_cache: WORDS_PER_LINE must be a power of 2 and >= 2");
    end
    if (LINES < 2 || (1 << IDX_W) != LINES) begin : g_bad_lines
        $error("inst_cache: LINES must be a power of 2 and >= 2");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("inst_cache: DATA_WIDTH too small for LINES x WORDS_PER_LINE");
    end

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

    state_t                r_state, w_next;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [DATA_WIDTH-1:0] r_data [LINES*WORDS_PER_LINE];
    logic [DATA_WIDTH-1:0] r_addr;
    logic [OFF_W-1:0]      r_beat;
    logic                  r_flush_pend;
    logic                  r_skip_install;

    logic [TAG_W-1:0]      w_tag;
    logic [IDX_W-1:0]      w_idx;
    logic [OFF_W-1:0]      w_off;
    logic                  w_flush_now;
    logic                  w_hit;
    logic                  w_last;

    assign w_tag       = r_addr[DATA_WIDTH-1 -: TAG_W];
    assign w_idx       = r_addr[2+OFF_W +: IDX_W];
    assign w_off       = r_addr[2 +: OFF_W];
    // A flush seen in the same cycle as a lookup forces a miss.
    assign w_flush_now = flush || r_flush_pend;
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !w_flush_now;
    assign w_last      = mem_valid && (r_beat == OFF_W'(WORDS_PER_LINE - 1));
    assign inst_valid  = (r_state == RESPOND);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = inst_req ? LOOKUP : IDLE;
            LOOKUP:  w_next = !inst_req ? IDLE : (w_hit ? RESPOND : REFILL);
            REFILL:  w_next = w_last ? LOOKUP : REFILL;
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_valid        <= '0;
            inst_data      <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            r_beat         <= '0;
            r_flush_pend   <= 1'b0;
            r_skip_install <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (inst_req) r_addr <= inst_addr;
                LOOKUP: begin
                    if (inst_req && w_hit) begin
                        inst_data <= r_data[{w_idx, w_off}];
                    end else if (inst_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= r_addr & ~LINE_MASK;
                        r_beat   <= '0;
                    end
                end
                REFILL: begin
                    if (mem_valid) begin
                        r_beat   <= r_beat + 1'b1;
                        mem_addr <= mem_addr + DATA_WIDTH'(4);
                    end
                    if (w_last) begin
                        r_valid[w_idx] <= !(r_skip_install || flush);
                        mem_req        <= 1'b0;
                        r_skip_install <= 1'b0;
                    end
                    if (flush) r_flush_pend <= 1'b1;
                    if (flush && !w_last) r_skip_install <= 1'b1;
                end
                RESPOND: if (flush) r_flush_pend <= 1'b1;
                default: ;
            endcase
            if ((r_state == IDLE || r_state == LOOKUP) && w_flush_now) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == REFILL && mem_valid) begin
            r_data[{w_idx, r_beat}] <= mem_rdata;
            if (w_last) r_tag[w_idx] <= w_tag;
        end
    end
endmodule
